// File: rtl/ram_burst_reader_if.sv
// Bundles the burst command, RAM read port and streaming output of ram_burst_reader.
// master = the reader itself, slave = the surrounding environment (RAM + consumer).
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, base_addr, length, ram_q, out_ready,
    output busy, done, ram_addr, ram_we, out_data, out_valid
  );

  modport slave (
    output start, base_addr, length, ram_q, out_ready,
    input  busy, done, ram_addr, ram_we, out_data, out_valid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Streams a wrap-around window of a registered-output RAM through a 4-entry FIFO,
// issuing reads only while FIFO occupancy plus in-flight reads leaves room.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  ram_burst_reader_if.master  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH:0]   len_q, issued_q;
  logic [ADDR_WIDTH-1:0] addr_q, nxt_addr_q;
  logic                  vld_p0, vld_p1;
  logic                  done_q, done_nxt;
  logic                  load, issue, push, pop;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occ;
  logic [2:0]            credit_used;

  assign push        = vld_p1;
  assign pop         = (occ != 3'd0) && bus.out_ready;
  assign credit_used = occ + {2'b00, vld_p0} + {2'b00, vld_p1};

  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            done_nxt = 1'b1;
          end else begin
            load      = 1'b1;
            issue     = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        issue = (issued_q < len_q) && (credit_used < 3'd4);
        // Last word leaves on this edge: everything issued, pipe drained, one left in FIFO.
        if ((issued_q == len_q) && !vld_p0 && !vld_p1 && (occ == 3'd1) && pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: address register; stage p1: RAM q register; then FIFO push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      nxt_addr_q <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      occ        <= 3'd0;
    end else begin
      state_q <= state_nxt;
      done_q  <= done_nxt;
      vld_p0  <= issue;
      vld_p1  <= vld_p0;
      if (load) begin
        len_q      <= bus.length;
        issued_q   <= (ADDR_WIDTH+1)'(1);
        addr_q     <= bus.base_addr;
        nxt_addr_q <= bus.base_addr + ADDR_WIDTH'(1);
      end else if (issue) begin
        issued_q   <= issued_q + (ADDR_WIDTH+1)'(1);
        addr_q     <= nxt_addr_q;
        nxt_addr_q <= nxt_addr_q + ADDR_WIDTH'(1);
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
      assert (!(push && !pop && (occ == 3'd4)));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.ram_q;
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = 1'b0;
  assign bus.out_valid = (occ != 3'd0);
  assign bus.out_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a registered-output RAM model
// and a transfer monitor recording every accepted word and done pulse.
module tb_ram_burst_reader;

  logic clk;
  logic reset;
  logic [7:0] ram [8];
  logic [7:0] got_q [$];
  int done_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;

  ram_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  ram_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_q <= ram[bus.ram_addr];

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [2:0] b, input logic [3:0] l, input int budget);
    int d0;
    d0 = done_cnt;
    bus.base_addr = b;
    bus.length    = l;
    bus.start     = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int i = 0; i < budget && done_cnt == d0; i++) step(1);
    chk("burst_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int g0, d0;
    for (int i = 0; i < 8; i++) ram[i] = 8'h10 + 8'(i);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.base_addr = 3'd0;
    bus.length = 4'd4;
    bus.out_ready = 1'b1;

    // Reset with start held high
    for (int c = 0; c < 2; c++) begin
      step(1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_we", bus.ram_we, 0);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    step(2);
    chk("idle_busy", bus.busy, 0);

    // Straight burst base=2 length=4, cycle-exact
    g0 = got_q.size();
    d0 = done_cnt;
    bus.base_addr = 3'd2;
    bus.length = 4'd4;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("k_busy", bus.busy, 1);
    chk("k_addr", bus.ram_addr, 2);
    chk("k_valid", bus.out_valid, 0);
    step(1);
    chk("k1_addr", bus.ram_addr, 3);
    chk("k1_valid", bus.out_valid, 0);
    step(1);
    chk("k2_addr", bus.ram_addr, 4);
    chk("k2_valid", bus.out_valid, 1);
    chk("k2_data", bus.out_data, 8'h12);
    step(1);
    chk("k3_addr", bus.ram_addr, 5);
    chk("k3_data", bus.out_data, 8'h13);
    step(1);
    chk("k4_addr", bus.ram_addr, 5);
    chk("k4_data", bus.out_data, 8'h14);
    step(1);
    chk("k5_data", bus.out_data, 8'h15);
    chk("k5_done", bus.done, 0);
    step(1);
    chk("k6_done", bus.done, 1);
    chk("k6_busy", bus.busy, 0);
    chk("k6_valid", bus.out_valid, 0);
    step(1);
    chk("k7_done", bus.done, 0);
    chk("straight_count", got_q.size() - g0, 4);
    for (int i = 0; i < 4; i++) chk("straight_word", got_q[g0 + i], 8'h12 + 8'(i));
    chk("straight_done_count", done_cnt - d0, 1);

    // Wrap past top of RAM
    g0 = got_q.size();
    burst(3'd6, 4'd4, 50);
    chk("wrap_count", got_q.size() - g0, 4);
    chk("wrap_w0", got_q[g0], 8'h16);
    chk("wrap_w1", got_q[g0 + 1], 8'h17);
    chk("wrap_w2", got_q[g0 + 2], 8'h10);
    chk("wrap_w3", got_q[g0 + 3], 8'h11);

    // Full depth from base 5
    g0 = got_q.size();
    burst(3'd5, 4'd8, 50);
    chk("full_count", got_q.size() - g0, 8);
    for (int i = 0; i < 8; i++) chk("full_word", got_q[g0 + i], 8'h10 + 8'((5 + i) % 8));
    chk("full_last_addr", bus.ram_addr, 4);

    // Backpressure: 10 cycles stalled, then alternating ready
    g0 = got_q.size();
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    bus.base_addr = 3'd0;
    bus.length = 4'd8;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(5);
    chk("bp_addr_mid", bus.ram_addr, 3);
    step(4);
    chk("bp_addr_stall", bus.ram_addr, 3);
    chk("bp_no_xfer", got_q.size() - g0, 0);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_head", bus.out_data, 8'h10);
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      bus.out_ready = (i % 2 == 0);
      step(1);
    end
    bus.out_ready = 1'b1;
    chk("bp_done_count", done_cnt - d0, 1);
    chk("bp_count", got_q.size() - g0, 8);
    for (int i = 0; i < 8; i++) chk("bp_word", got_q[g0 + i], 8'h10 + 8'(i));

    // Zero length
    g0 = got_q.size();
    bus.base_addr = 3'd1;
    bus.length = 4'd0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_valid", bus.out_valid, 0);
    step(1);
    chk("len0_done_drop", bus.done, 0);
    chk("len0_valid2", bus.out_valid, 0);
    chk("len0_count", got_q.size() - g0, 0);

    // Start held every cycle of a length-4 burst; later starts ignored
    g0 = got_q.size();
    d0 = done_cnt;
    bus.base_addr = 3'd0;
    bus.length = 4'd4;
    bus.start = 1'b1;
    step(1);
    bus.base_addr = 3'd5;
    bus.length = 4'd2;
    for (int i = 0; i < 50 && !bus.done; i++) step(1);
    bus.start = 1'b0;
    step(3);
    chk("hold_count", got_q.size() - g0, 4);
    for (int i = 0; i < 4; i++) chk("hold_word", got_q[g0 + i], 8'h10 + 8'(i));
    chk("hold_done_count", done_cnt - d0, 1);
    chk("hold_busy", bus.busy, 0);

    // Reset after second transfer of a length-8 burst
    g0 = got_q.size();
    d0 = done_cnt;
    bus.base_addr = 3'd0;
    bus.length = 4'd8;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int i = 0; i < 50 && (got_q.size() - g0) < 2; i++) step(1);
    chk("mid_two_xfers", got_q.size() - g0, 2);
    reset = 1'b1;
    step(1);
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_addr", bus.ram_addr, 0);
    reset = 1'b0;
    step(3);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_more", bus.out_valid, 0);
    g0 = got_q.size();
    burst(3'd3, 4'd2, 50);
    chk("after_count", got_q.size() - g0, 2);
    chk("after_w0", got_q[g0], 8'h13);
    chk("after_w1", got_q[g0 + 1], 8'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
# ram_burst_reader

Read-side sequencer that sits directly downstream of a `single_port_ram` instance. On `start` it walks a contiguous, wrap-around address window of `length` words starting at `base_addr`. It streams the returned words out over a valid/ready interface with full backpressure and no data loss. Sustained throughput is 1 word/cycle when the consumer is always ready, which lets the convolution datapath pull weight and activation bursts from on-chip RAM.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: RAM word width.
- `ADDR_WIDTH`, default 3: RAM address width; the RAM depth is 2^ADDR_WIDTH.

Ports:
- `clk` (in, 1): the single clock; all state updates on its rising edge.
- `reset` (in, 1): synchronous, active-high reset.
- `start` (in, 1): begin a burst; sampled only while `busy`=0.
- `base_addr` (in, ADDR_WIDTH): first address of the burst; captured when `start` is accepted.
- `length` (in, ADDR_WIDTH+1): word count, 0..2^ADDR_WIDTH; captured when `start` is accepted.
- `busy` (out, 1): a burst is in progress.
- `done` (out, 1): one-cycle pulse when a burst completes.
- `ram_addr` (out, ADDR_WIDTH): registered address driven to the RAM's `addr`.
- `ram_we` (out, 1): constant 0; connects to the RAM's `we`.
- `ram_q` (in, DATA_WIDTH): the RAM's `q` output.
- `out_data` (out, DATA_WIDTH): head word of the output FIFO.
- `out_valid` (out, 1): `out_data` is valid.
- `out_ready` (in, 1): the consumer accepts the word. A transfer occurs on a rising edge where `out_valid` and `out_ready` are both 1.

## Operation
- RAM model: `q` is registered. A value of `ram_addr` that is stable before edge e appears on `ram_q` after edge e.
- States:
  - IDLE: `busy`=0. If `start`=1, capture `base_addr` and `length`. If length=0, stay in IDLE and pulse `done` next cycle. Otherwise go to RUN.
  - RUN: issue reads until `length` reads have been issued. Then wait until all words have transferred out. Then go to IDLE with a `done` pulse.
- Read issue:
  - A read is issued in a cycle when fewer than `length` reads have been issued and (FIFO occupancy + in-flight reads) < 4.
  - Issuing means `ram_addr` <= next address. The next address starts at `base_addr` and increments modulo 2^ADDR_WIDTH, so window addresses wrap past the top of the RAM.
  - Do not issue when the credit check fails. Never drop a word.
- In-flight tracking:
  - Each issued read is tagged through a 2-stage valid pipe: the address stage and the RAM q stage.
  - The returned `ram_q` is pushed into the FIFO on the edge after the RAM's q update.
- Output FIFO:
  - 4 entries, circular pointers.
  - `out_valid` = (occupancy != 0); `out_data` = the head entry.
  - Push and pop in the same cycle leave occupancy unchanged.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- `start` while `busy`=1 is ignored; it is not queued.
- `length` counts use ADDR_WIDTH+1 bits so that a full-depth burst (2^ADDR_WIDTH words) is legal. That burst visits every address exactly once.

## Timing
- Reset: `busy`=0, `done`=0, `out_valid`=0, `ram_addr`=0, `ram_we`=0. Reset also empties the FIFO and clears the in-flight pipe and counters. `out_data` is don't-care while `out_valid`=0.
- Reset asserted mid-burst: the burst is aborted with no `done` pulse. Outputs take their reset values after that edge.
- Let edge k sample `start`=1 in IDLE with length≥1:
  - Edge k: `busy`=1 and `ram_addr`=base.
  - Edge k+1: `ram_q` = word 0.
  - Edge k+2: word 0 is in the FIFO and `out_valid`=1.
  - First-word latency is 3 edges from `start` to a transferable word.
- With `out_ready` held at 1, words transfer on consecutive edges k+3 … k+2+length.
  - `done`=1 and `busy`=0 for the one cycle after the last transfer edge.
  - A new `start` is accepted on the edge where `done`=1.
- length=0: `done`=1 for the cycle after edge k; `busy` stays 0; `out_valid` stays 0.
- Backpressure: with `out_ready`=0, at most 4 words are outstanding (FIFO plus in flight). `ram_addr` holds its value. No read is lost or duplicated.

## Test plan
- Reset values: assert `reset` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `out_valid`=0, `ram_addr`=0 throughout.
- Straight burst: preload RAM[i]=0x10+i; start with base=2, length=4, `out_ready`=1 → `ram_addr` sequence 2,3,4,5; out words 0x12,0x13,0x14,0x15 on 4 consecutive edges starting at k+3; single `done` pulse after the last word.
- Wrap and full depth:
  - base=6, length=4 → out 0x16,0x17,0x10,0x11.
  - base=5, length=8 → all 8 words exactly once, ending at address 4.
- Backpressure: base=0, length=8; `out_ready`=0 for 10 cycles, then alternate 1/0 → in-order 0x10..0x17 with no loss or duplicates; FIFO occupancy ≤4; `ram_addr` stalls while credits are exhausted.
- Edge commands:
  - length=0 → `done` pulse, no `out_valid`.
  - `start` pulsed at every cycle of a length-4 burst → only the first start is accepted; exactly 4 words and 1 `done`.
- Reset mid-burst: reset after the 2nd transfer of a length-8 burst → no `done`, `out_valid`=0 next cycle. A subsequent start with base=3, length=2 → out 0x13,0x14.
